// File: rtl/bullet_ctrl.sv
// bullet_ctrl -- per-player bullet engine for the tank game.
//
// Launches a bullet from the leading edge of the tank and moves it once per
// video frame. Draws the bullet, or its explosion, against the current VGA
// scan position. bullet_o feeds the collision stage. That stage answers on
// explode_i when the bullet hits something at the current pixel.
//
// Ports:
//   clk_i         pixel clock
//   rst_ni        asynchronous active-low reset
//   frame_tick_i  one-cycle pulse per frame (start of vblank)
//   fire_i        fire button, synchronised level
//   tank_x_i/y_i  tank box top-left corner
//   tank_dir_i    00 up, 01 right, 10 down, 11 left
//   pixel_x_i/y_i current scan position
//   explode_i     bullet hit a hard block or a tank at this pixel
//   bullet_o      scan pixel lies inside the bullet box (FLYING only)
//   explosion_o   scan pixel lies inside the explosion box (EXPLODE only)
//   active_o      engine is not idle
//   bullet_x_o/y_o bullet box top-left corner
//
// Build option: define BULLET_AUTOFIRE_EN to enable autofire. With it,
// holding fire relaunches as soon as the cooldown allows. Without it, the
// player must release fire and press it again.

module bullet_ctrl #(
    parameter int unsigned COORD_W         = 10,
    parameter int unsigned SCREEN_W        = 640,
    parameter int unsigned SCREEN_H        = 480,
    parameter int unsigned TANK_SIZE       = 32,
    parameter int unsigned BULLET_SIZE     = 4,
    parameter int unsigned BULLET_SPEED    = 4,
    parameter int unsigned EXPLODE_FRAMES  = 8,
    parameter int unsigned COOLDOWN_FRAMES = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               frame_tick_i,
    input  logic               fire_i,
    input  logic [COORD_W-1:0] tank_x_i,
    input  logic [COORD_W-1:0] tank_y_i,
    input  logic [1:0]         tank_dir_i,
    input  logic [COORD_W-1:0] pixel_x_i,
    input  logic [COORD_W-1:0] pixel_y_i,
    input  logic               explode_i,
    output logic               bullet_o,
    output logic               explosion_o,
    output logic               active_o,
    output logic [COORD_W-1:0] bullet_x_o,
    output logic [COORD_W-1:0] bullet_y_o
);

    // One extra bit of headroom so far-edge sums never wrap.
    localparam int unsigned AW   = COORD_W + 1;
    localparam int unsigned EC_W = $clog2(EXPLODE_FRAMES + 1);
    localparam int unsigned CD_W = $clog2(COOLDOWN_FRAMES + 1);

    localparam logic [AW-1:0] BS   = AW'(BULLET_SIZE);
    localparam logic [AW-1:0] SPD  = AW'(BULLET_SPEED);
    localparam logic [AW-1:0] TS   = AW'(TANK_SIZE);
    localparam logic [AW-1:0] CTR  = AW'(TANK_SIZE / 2 - BULLET_SIZE / 2);
    localparam logic [AW-1:0] SW   = AW'(SCREEN_W);
    localparam logic [AW-1:0] SH   = AW'(SCREEN_H);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLYING,
        ST_EXPLODE
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    state_t             state_q, state_d;
    dir_t               dir_q, dir_d;
    logic [COORD_W-1:0] bx_q, bx_d, by_q, by_d;
    logic [EC_W-1:0]    exp_cnt_q, exp_cnt_d;
    logic [CD_W-1:0]    cool_q, cool_d;
    logic               armed_q, armed_d;

    logic [AW-1:0] tx, ty, sx, sy, bxw, byw, nx, ny;
    logic          spawn_uf, spawn_ok, move_uf, move_off;

    assign tx  = {1'b0, tank_x_i};
    assign ty  = {1'b0, tank_y_i};
    assign bxw = {1'b0, bx_q};
    assign byw = {1'b0, by_q};

    // Candidate spawn at the tank's leading edge, centred across its face.
    always_comb begin
        sx       = tx + CTR;
        sy       = ty - BS;
        spawn_uf = 1'b0;
        unique case (dir_t'(tank_dir_i))
            DIR_UP: begin
                sx       = tx + CTR;
                sy       = ty - BS;
                spawn_uf = (ty < BS);
            end
            DIR_DOWN: begin
                sx = tx + CTR;
                sy = ty + TS;
            end
            DIR_LEFT: begin
                sx       = tx - BS;
                sy       = ty + CTR;
                spawn_uf = (tx < BS);
            end
            DIR_RIGHT: begin
                sx = tx + TS;
                sy = ty + CTR;
            end
        endcase
        spawn_ok = !spawn_uf && (sx + BS <= SW) && (sy + BS <= SH);
    end

    // Next position one step along the latched direction.
    always_comb begin
        nx      = bxw;
        ny      = byw;
        move_uf = 1'b0;
        unique case (dir_q)
            DIR_UP: begin
                ny      = byw - SPD;
                move_uf = (byw < SPD);
            end
            DIR_DOWN:  ny = byw + SPD;
            DIR_LEFT: begin
                nx      = bxw - SPD;
                move_uf = (bxw < SPD);
            end
            DIR_RIGHT: nx = bxw + SPD;
        endcase
        move_off = move_uf || (nx + BS > SW) || (ny + BS > SH);
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        bx_d      = bx_q;
        by_d      = by_q;
        exp_cnt_d = exp_cnt_q;
        cool_d    = cool_q;
        armed_d   = armed_q;

        unique case (state_q)
            ST_IDLE: begin
                if (frame_tick_i) begin
                    if (cool_q != '0) begin
                        cool_d = cool_q - 1'b1;
                    end else if (fire_i && armed_q && spawn_ok) begin
                        state_d = ST_FLYING;
                        dir_d   = dir_t'(tank_dir_i);
                        bx_d    = sx[COORD_W-1:0];
                        by_d    = sy[COORD_W-1:0];
                        armed_d = 1'b0;
                    end
                end
            end
            ST_FLYING: begin
                // A hit beats a coincident frame tick; position stays frozen.
                if (explode_i) begin
                    state_d   = ST_EXPLODE;
                    exp_cnt_d = EC_W'(EXPLODE_FRAMES);
                end else if (frame_tick_i) begin
                    if (move_off) begin
                        state_d = ST_IDLE;
                        cool_d  = CD_W'(COOLDOWN_FRAMES);
                    end else begin
                        bx_d = nx[COORD_W-1:0];
                        by_d = ny[COORD_W-1:0];
                    end
                end
            end
            ST_EXPLODE: begin
                if (frame_tick_i) begin
                    exp_cnt_d = exp_cnt_q - 1'b1;
                    if (exp_cnt_q == EC_W'(1)) begin
                        state_d = ST_IDLE;
                        cool_d  = CD_W'(COOLDOWN_FRAMES);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef BULLET_AUTOFIRE_EN
        armed_d = 1'b1;
`else
        // Launch only happens with fire_i high, so re-arming never collides
        // with the clear above.
        if (frame_tick_i && !fire_i) begin
            armed_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_UP;
            bx_q      <= '0;
            by_q      <= '0;
            exp_cnt_q <= '0;
            cool_q    <= '0;
            armed_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            exp_cnt_q <= exp_cnt_d;
            cool_q    <= cool_d;
            armed_q   <= armed_d;
        end
    end

    // Pixel outputs are combinational, so the collision stage sees the same
    // scan pixel it is judging.
    logic [AW-1:0] px, py, ex_lo, ey_lo;
    logic          in_bullet, in_explosion;

    assign px    = {1'b0, pixel_x_i};
    assign py    = {1'b0, pixel_y_i};
    assign ex_lo = (bxw >= BS) ? bxw - BS : '0;
    assign ey_lo = (byw >= BS) ? byw - BS : '0;

    assign in_bullet    = (px >= bxw) && (px < bxw + BS) &&
                          (py >= byw) && (py < byw + BS);
    assign in_explosion = (px >= ex_lo) && (px < bxw + BS + BS) &&
                          (py >= ey_lo) && (py < byw + BS + BS);

    assign bullet_o    = (state_q == ST_FLYING) && in_bullet;
    assign explosion_o = (state_q == ST_EXPLODE) && in_explosion;
    assign active_o    = (state_q != ST_IDLE);
    assign bullet_x_o  = bx_q;
    assign bullet_y_o  = by_q;

endmodule

// File: tb/tb_bullet_ctrl.sv
// tb_bullet_ctrl -- scoreboard bench for bullet_ctrl.
// Expected values are queued as stimulus is applied and are compared once
// the DUT has produced the corresponding output.

module tb_bullet_ctrl;

    localparam int unsigned COORD_W = 10;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               frame_tick_i;
    logic               fire_i;
    logic [COORD_W-1:0] tank_x_i, tank_y_i;
    logic [1:0]         tank_dir_i;
    logic [COORD_W-1:0] pixel_x_i, pixel_y_i;
    logic               explode_i;
    logic               bullet_o, explosion_o, active_o;
    logic [COORD_W-1:0] bullet_x_o, bullet_y_o;

    bullet_ctrl #(
        .COORD_W(COORD_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .frame_tick_i(frame_tick_i),
        .fire_i      (fire_i),
        .tank_x_i    (tank_x_i),
        .tank_y_i    (tank_y_i),
        .tank_dir_i  (tank_dir_i),
        .pixel_x_i   (pixel_x_i),
        .pixel_y_i   (pixel_y_i),
        .explode_i   (explode_i),
        .bullet_o    (bullet_o),
        .explosion_o (explosion_o),
        .active_o    (active_o),
        .bullet_x_o  (bullet_x_o),
        .bullet_y_o  (bullet_y_o)
    );

    always #5 clk_i = ~clk_i;

    typedef enum int {O_ACTIVE, O_BX, O_BY, O_BULLET, O_EXPL} obs_t;
    typedef struct {
        string       tag;
        obs_t        sel;
        int unsigned val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic push_exp(input string tag, input obs_t sel, input int unsigned val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        int unsigned got;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                O_ACTIVE: got = int'(active_o);
                O_BX:     got = int'(bullet_x_o);
                O_BY:     got = int'(bullet_y_o);
                O_BULLET: got = int'(bullet_o);
                default:  got = int'(explosion_o);
            endcase
            check_eq(e.tag, got, e.val);
        end
    endtask

    // Called at a falling edge; applies one frame tick and returns at the
    // next falling edge.
    task automatic tick(input logic fire, input logic expl);
        fire_i       = fire;
        explode_i    = expl;
        frame_tick_i = 1'b1;
        @(posedge clk_i);
        #1;
        frame_tick_i = 1'b0;
        explode_i    = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic probe(input string tag, input int unsigned x, input int unsigned y,
                         input int unsigned eb, input int unsigned ee);
        pixel_x_i = COORD_W'(x);
        pixel_y_i = COORD_W'(y);
        #1;
        push_exp({tag, "_bul"}, O_BULLET, eb);
        push_exp({tag, "_exp"}, O_EXPL, ee);
        drain();
    endtask

    task automatic expect_pos(input string tag, input int unsigned act,
                              input int unsigned x, input int unsigned y);
        push_exp({tag, "_act"}, O_ACTIVE, act);
        push_exp({tag, "_x"}, O_BX, x);
        push_exp({tag, "_y"}, O_BY, y);
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni       = 1'b0;
        frame_tick_i = 1'b0;
        fire_i       = 1'b0;
        explode_i    = 1'b0;
        tank_x_i     = '0;
        tank_y_i     = '0;
        tank_dir_i   = 2'b00;
        pixel_x_i    = '0;
        pixel_y_i    = '0;

        repeat (3) @(negedge clk_i);
        expect_pos("rst", 0, 0, 0);
        probe("rst_pix", 0, 0, 0, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Launch to the right from (100,200).
        tank_x_i   = 10'd100;
        tank_y_i   = 10'd200;
        tank_dir_i = 2'b01;
        tick(1'b1, 1'b0);
        expect_pos("launch", 1, 132, 214);
        tick(1'b1, 1'b0);
        expect_pos("move1", 1, 136, 214);
        for (int x = 134; x <= 141; x++)
            probe("bul_row", x, 215, (x >= 136 && x <= 139) ? 1 : 0, 0);
        probe("bul_top_out", 137, 213, 0, 0);
        probe("bul_top_in", 137, 214, 1, 0);
        probe("bul_bot_in", 137, 217, 1, 0);
        probe("bul_bot_out", 137, 218, 0, 0);

        // Hit coincident with a frame tick: no move, explosion box 132..143 x 210..221.
        tick(1'b1, 1'b1);
        expect_pos("hit", 1, 136, 214);
        probe("ex_c", 137, 215, 0, 1);
        probe("ex_l_out", 131, 215, 0, 0);
        probe("ex_l_in", 132, 215, 0, 1);
        probe("ex_r_in", 143, 215, 0, 1);
        probe("ex_r_out", 144, 215, 0, 0);
        probe("ex_t_out", 137, 209, 0, 0);
        probe("ex_t_in", 137, 210, 0, 1);
        probe("ex_b_in", 137, 221, 0, 1);
        probe("ex_b_out", 137, 222, 0, 0);

        // A repeated explode_i in EXPLODE must not restart the count.
        tick(1'b1, 1'b1);
        repeat (6) tick(1'b1, 1'b0);
        expect_pos("exp_7", 1, 136, 214);
        tick(1'b1, 1'b0);
        expect_pos("exp_end", 0, 136, 214);

        // Cooldown: tick 1 fire held, release, tick 16 pressed too early, tick 17 launches.
        tick(1'b1, 1'b0);
        push_exp("cool_t1", O_ACTIVE, 0);
        drain();
        repeat (14) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        push_exp("cool_t16", O_ACTIVE, 0);
        drain();
        tick(1'b1, 1'b0);
        expect_pos("cool_t17", 1, 132, 214);

        // Asynchronous reset between clock edges.
        probe("pre_rst", 133, 215, 1, 0);
        #2;
        rst_ni = 1'b0;
        #1;
        expect_pos("arst", 0, 0, 0);
        probe("arst_pix", 133, 215, 0, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        tick(1'b0, 1'b0);
        push_exp("post_rst", O_ACTIVE, 0);
        drain();

        // Top edge: spawn at y=6, step to 2, then leave the screen without wrapping.
        tank_x_i   = 10'd100;
        tank_y_i   = 10'd10;
        tank_dir_i = 2'b00;
        tick(1'b1, 1'b0);
        expect_pos("up_spawn", 1, 114, 6);
        tick(1'b1, 1'b0);
        expect_pos("up_move", 1, 114, 2);
        tick(1'b1, 1'b0);
        expect_pos("up_off", 0, 114, 2);
        repeat (16) tick(1'b0, 1'b0);

        // Illegal spawn leaves the block idle and keeps it armed.
        tank_y_i = 10'd2;
        tick(1'b1, 1'b0);
        push_exp("spawn_illegal", O_ACTIVE, 0);
        drain();
        tank_y_i = 10'd50;
        tick(1'b1, 1'b0);
        expect_pos("spawn_legal", 1, 114, 46);

        // Fire held through explosion and cooldown: relaunch only with autofire.
        tick(1'b1, 1'b1);
        repeat (8) tick(1'b1, 1'b0);
        push_exp("af_exp_end", O_ACTIVE, 0);
        drain();
        repeat (16) tick(1'b1, 1'b0);
        push_exp("af_t16", O_ACTIVE, 0);
        drain();
        tick(1'b1, 1'b0);
`ifdef BULLET_AUTOFIRE_EN
        expect_pos("af_relaunch", 1, 114, 46);
`else
        push_exp("no_relaunch", O_ACTIVE, 0);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
